// File: rtl/lattice_opendrain_output.sv
// Open-drain pad cell: the pad is only ever pulled to GND or released to the pull-up.
// Behaves as an SB_IO with PULLUP=1, D_OUT_0 tied 0, OE from the caller and unregistered input.
module lattice_opendrain_output (
  input  logic oe_i,
  output logic din_o,
  inout  wire  pad_io
);

  assign pad_io = oe_i ? 1'b0 : 1'bz;
  assign din_o  = pad_io;

endmodule

// File: rtl/lattice_button_press_emulator.sv
// Emulates a mechanical button on an open-drain pad: queued requests become fixed-length
// low pulses, each followed by a release gap that only counts cycles the pad reads high.
module lattice_button_press_emulator #(
  parameter int  PRESS_CYCLES   = 200,
  parameter int  RELEASE_CYCLES = 200,
  parameter int  MAX_PENDING    = 7,
  localparam int PW             = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          press,
  inout  wire           pin,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          dropped,
  output logic          pin_sense
);

  // state      | meaning
  // ST_IDLE    | pad released, waiting for a queued request
  // ST_PRESS   | pad driven low for PRESS_CYCLES clocks
  // ST_RELEASE | pad released, waiting for RELEASE_CYCLES clocks of sensed high
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] PRESS_LOAD   = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LOAD = CW'(RELEASE_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX     = PW'(MAX_PENDING);

  if (PRESS_CYCLES < 1 || RELEASE_CYCLES < 1 || MAX_PENDING < 1) begin : g_param_err
    $error("lattice_button_press_emulator: PRESS_CYCLES, RELEASE_CYCLES and MAX_PENDING must be >= 1");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          dropped_q, dropped_d;
  logic          sync1_q, sync2_q;
  logic          pad_in;
  logic          inc, dec;

  lattice_opendrain_output u_pad (
    .oe_i   (oe_q),
    .din_o  (pad_in),
    .pad_io (pin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
      sync1_q   <= pad_in;
      sync2_q   <= sync1_q;
    end
  end

  // A request arriving while one is being dequeued never overflows, even when full.
  always_comb begin
    inc       = press;
    dec       = (state_q == ST_IDLE) && (pend_q != '0);
    pend_d    = pend_q;
    dropped_d = 1'b0;
    if (inc && !dec) begin
      if (pend_q == PEND_MAX) dropped_d = 1'b1;
      else                    pend_d    = pend_q + 1'b1;
    end else if (!inc && dec) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) begin
          state_d = ST_PRESS;
          cnt_d   = PRESS_LOAD;
          oe_d    = 1'b1;
        end
      end
      ST_PRESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
          cnt_d   = RELEASE_LOAD;
          oe_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        // Any sensed low (slow rise or someone else pressing) restarts the gap.
        if (!sync2_q)           cnt_d   = RELEASE_LOAD;
        else if (cnt_q == '0)   state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        oe_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign busy      = busy_q;
  assign pending   = pend_q;
  assign dropped   = dropped_q;
  assign pin_sense = sync2_q;

endmodule

// File: tb/tb_lattice_button_press_emulator.sv
// Directed bench for lattice_button_press_emulator with PRESS=4, RELEASE=3, MAX_PENDING=2
// and a weak pull-up on the pad.
module tb_lattice_button_press_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       press = 1'b0;
  logic       ext_low = 1'b0;
  wire        pin;
  logic       busy, dropped, pin_sense;
  logic [1:0] pending;

  int n_checks = 0;
  int n_err    = 0;

  pullup (pin);
  assign pin = ext_low ? 1'b0 : 1'bz;

  lattice_button_press_emulator #(
    .PRESS_CYCLES   (4),
    .RELEASE_CYCLES (3),
    .MAX_PENDING    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .press     (press),
    .pin       (pin),
    .busy      (busy),
    .pending   (pending),
    .dropped   (dropped),
    .pin_sense (pin_sense)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       press;
    logic       ext_low;
    logic       rst_in;
    logic       exp_pin;
    logic       exp_busy;
    logic [1:0] exp_pend;
    logic       exp_drop;
    logic       exp_sense;
  } vec_t;

  vec_t vq[$];

  function automatic void add(string n, int p, int e, int r, int pn, int b, int pd, int d, int s);
    vq.push_back('{n, p[0], e[0], r[0], pn[0], b[0], pd[1:0], d[0], s[0]});
  endfunction

  task automatic chk(string what, logic [1:0] got, logic [1:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%b want=%b", what, got, want);
    end
  endtask

  task automatic chk_int(string what, int got, int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", what, got, want);
    end
  endtask

  // Each row: compare the outputs of the current cycle, then drive the inputs for the next edge.
  task automatic run_rows(int a, int b);
    for (int i = a; i <= b; i++) begin
      chk($sformatf("%s[%0d] pin", vq[i].name, i - a), {1'b0, pin}, {1'b0, vq[i].exp_pin});
      chk($sformatf("%s[%0d] busy", vq[i].name, i - a), {1'b0, busy}, {1'b0, vq[i].exp_busy});
      chk($sformatf("%s[%0d] pending", vq[i].name, i - a), pending, vq[i].exp_pend);
      chk($sformatf("%s[%0d] dropped", vq[i].name, i - a), {1'b0, dropped}, {1'b0, vq[i].exp_drop});
      chk($sformatf("%s[%0d] pin_sense", vq[i].name, i - a), {1'b0, pin_sense}, {1'b0, vq[i].exp_sense});
      press   = vq[i].press;
      ext_low = vq[i].ext_low;
      rst     = vq[i].rst_in;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(string what);
    int k = 0;
    while ((busy !== 1'b0 || pending !== 2'd0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (busy !== 1'b0 || pending !== 2'd0) begin
      n_err++;
      $display("FAIL %s drain timeout busy=%b pending=%0d want busy=0 pending=0", what, busy, pending);
    end
  endtask

  // Pad monitor: counts presses and measures low pulse widths and high gaps.
  bit prev_pin  = 1'b1;
  bit mon_on    = 1'b0;
  bit drop_seen = 1'b0;
  int low_len   = 0;
  int high_len  = 100;
  int n_falls   = 0;

  always @(negedge clk) begin
    if (mon_on && dropped !== 1'b0) drop_seen = 1'b1;
    if (pin === 1'b0) begin
      if (prev_pin) begin
        n_falls++;
        if (mon_on) begin
          n_checks++;
          if (high_len < 5) begin
            n_err++;
            $display("FAIL stream gap got=%0d want>=5", high_len);
          end
        end
        low_len = 1;
      end else begin
        low_len++;
      end
      high_len = 0;
    end else begin
      if (!prev_pin && mon_on) begin
        n_checks++;
        if (low_len != 4) begin
          n_err++;
          $display("FAIL stream low width got=%0d want=4", low_len);
        end
      end
      high_len = prev_pin ? high_len + 1 : 1;
    end
    prev_pin = (pin !== 1'b0);
  end

  int t1s, t1e, t2s, t2e, t3s, t3e, t4s, t4e, t5s, t5e;
  int n0;

  initial begin
    //  name  press ext rst | pin busy pend drop sense
    t1s = vq.size();
    for (int i = 0; i < 10; i++) add("idle", 0,0,0, 1,0,0,0,1);
    t1e = vq.size() - 1;

    t2s = vq.size();
    add("single", 1,0,0, 1,0,0,0,1);
    add("single", 0,0,0, 1,0,1,0,1);
    add("single", 0,0,0, 0,1,0,0,1);
    add("single", 0,0,0, 0,1,0,0,1);
    add("single", 0,0,0, 0,1,0,0,0);
    add("single", 0,0,0, 0,1,0,0,0);
    add("single", 0,0,0, 1,1,0,0,0);
    add("single", 0,0,0, 1,1,0,0,0);
    add("single", 0,0,0, 1,1,0,0,1);
    add("single", 0,0,0, 1,1,0,0,1);
    add("single", 0,0,0, 1,1,0,0,1);
    add("single", 0,0,0, 1,0,0,0,1);
    add("single", 0,0,0, 1,0,0,0,1);
    t2e = vq.size() - 1;

    t3s = vq.size();
    add("held", 1,0,0, 1,0,0,0,1);
    add("held", 1,0,0, 1,0,1,0,1);
    add("held", 1,0,0, 0,1,1,0,1);
    add("held", 1,0,0, 0,1,2,0,1);
    add("held", 0,0,0, 0,1,2,1,0);
    add("held", 0,0,0, 0,1,2,0,0);
    t3e = vq.size() - 1;

    t4s = vq.size();
    add("extlow", 1,0,0, 1,0,0,0,1);
    add("extlow", 1,0,0, 1,0,1,0,1);
    add("extlow", 0,0,0, 0,1,1,0,1);
    add("extlow", 0,0,0, 0,1,1,0,1);
    add("extlow", 0,0,0, 0,1,1,0,0);
    add("extlow", 0,0,0, 0,1,1,0,0);
    add("extlow", 0,0,0, 1,1,1,0,0);
    add("extlow", 0,1,0, 1,1,1,0,0);
    add("extlow", 0,1,0, 0,1,1,0,1);
    add("extlow", 0,1,0, 0,1,1,0,0);
    add("extlow", 0,1,0, 0,1,1,0,0);
    add("extlow", 0,1,0, 0,1,1,0,0);
    add("extlow", 0,0,0, 0,1,1,0,0);
    add("extlow", 0,0,0, 1,1,1,0,0);
    add("extlow", 0,0,0, 1,1,1,0,1);
    add("extlow", 0,0,0, 1,1,1,0,1);
    add("extlow", 0,0,0, 1,1,1,0,1);
    add("extlow", 0,0,0, 1,0,1,0,1);
    add("extlow", 0,0,0, 0,1,0,0,1);
    t4e = vq.size() - 1;

    t5s = vq.size();
    add("rstmid", 1,0,0, 1,0,0,0,1);
    add("rstmid", 0,0,0, 1,0,1,0,1);
    add("rstmid", 1,0,0, 0,1,0,0,1);
    add("rstmid", 0,0,1, 0,1,1,0,1);
    for (int i = 0; i < 6; i++) add("rstmid", 0,0,0, 1,0,0,0,1);
    t5e = vq.size() - 1;

    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_rows(t1s, t1e);
    run_rows(t2s, t2e);

    n0 = n_falls;
    run_rows(t3s, t3e);
    wait_idle("held");
    chk_int("held press count", n_falls - n0, 3);
    repeat (3) @(negedge clk);

    run_rows(t4s, t4e);
    wait_idle("extlow");
    repeat (3) @(negedge clk);

    run_rows(t5s, t5e);

    n0        = n_falls;
    drop_seen = 1'b0;
    mon_on    = 1'b1;
    for (int k = 0; k < 200; k++) begin
      press = (k % 20 == 0);
      @(negedge clk);
    end
    press = 1'b0;
    wait_idle("stream");
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    chk_int("stream press count", n_falls - n0, 10);
    chk("stream dropped seen", {1'b0, drop_seen}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
